// File: rtl/mul32_arb_if.sv
// mul32_arb_if: request/response bundle between client blocks and mul32_arb.
// Clients use the master modport; the arbiter uses the slave modport.
interface mul32_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 32
) ();
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_mc;
  logic [NREQ*W-1:0] req_mp;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_p;
  logic              rsp_err;

  modport master (
    output req_valid, req_mc, req_mp,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );

  modport slave (
    input  req_valid, req_mc, req_mp,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );
endinterface

// File: rtl/mul32_arb.sv
// mul32_arb: round-robin arbiter and controller sharing one mul32 among NREQ
// requesters. One job at a time: grant, register operands, pulse start, wait
// for the done rising edge, return the tagged product.
// Optional watchdog abort: define MUL32_ARB_WDOG_EN.
module mul32_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mul32_arb_if.slave   cli,
  output logic         busy,
  output logic         mul_start,
  output logic [W-1:0] mul_mc,
  output logic [W-1:0] mul_mp,
  input  logic         mul_done,
  input  logic [W-1:0] mul_p
);

  localparam int SW = IDW + 1;

  // Reject configurations the pointer arithmetic cannot represent
  if (NREQ < 2 || NREQ > (1 << IDW) || TIMEOUT < 1) begin : g_bad_params
    $error("mul32_arb: illegal NREQ/IDW/TIMEOUT combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  job_id_r;
  logic [IDW-1:0]  grant_id_s;
  logic [IDW-1:0]  rr_next_s;
  logic [SW-1:0]   sum_s;
  logic [NREQ-1:0] grant_s;
  logic            found_s;
  logic            xfer_s;
  logic            done_q_r;
  logic            done_rise_s;
  logic            timeout_s;
  logic [W-1:0]    sel_mc_s;
  logic [W-1:0]    sel_mp_s;
  logic [W-1:0]    mul_mc_r;
  logic [W-1:0]    mul_mp_r;
  logic [W-1:0]    rsp_p_r;
  logic [IDW-1:0]  rsp_id_r;
  logic            rsp_err_r;
  logic            rsp_valid_r;
  logic            busy_r;
  logic            mul_start_r;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping to 0
  always_comb begin
    grant_id_s = '0;
    found_s    = 1'b0;
    sum_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + SW'(k);
      if (sum_s >= SW'(NREQ)) begin
        sum_s = sum_s - SW'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && cli.req_valid[sum_s[IDW-1:0]]) begin
        found_s    = 1'b1;
        grant_id_s = sum_s[IDW-1:0];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // One-hot ready, only offered while idle
  always_comb begin
    grant_s = '0;
    if (found_s && (state_r == IDLE)) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_mc_s = '0;
    sel_mp_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id_s == IDW'(k)) begin
        sel_mc_s = cli.req_mc[k*W +: W];
        sel_mp_s = cli.req_mp[k*W +: W];
      end else begin
        sel_mc_s = sel_mc_s;
        sel_mp_s = sel_mp_s;
      end
    end
  end

  assign xfer_s      = found_s && (state_r == IDLE);
  assign rr_next_s   = (grant_id_s == IDW'(NREQ - 1)) ? '0 : grant_id_s + IDW'(1);
  // A done level still high from the previous job is not a completion
  assign done_rise_s = (state_r == BUSY) && mul_done && !done_q_r;

`ifdef MUL32_ARB_WDOG_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wdog_r;

  // Watchdog: cleared while starting a job, counts cycles spent in BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= '0;
    end else if (state_r == START) begin
      wdog_r <= '0;
    end else if (state_r == BUSY) begin
      wdog_r <= wdog_r + CW'(1);
    end else begin
      wdog_r <= wdog_r;
    end
  end

  assign timeout_s = (state_r == BUSY) && (wdog_r == CW'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_s = START;
        else        state_s = IDLE;
      end
      START: state_s = BUSY;
      BUSY: begin
        if (done_rise_s || timeout_s) state_s = RESP;
        else                          state_s = BUSY;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status strobes registered from the next state so they align with state_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      mul_start_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      busy_r      <= (state_s != IDLE);
      mul_start_r <= (state_s == START);
      rsp_valid_r <= (state_s == RESP);
    end
  end

  // Datapath: operand capture on grant, result capture on completion or abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q_r  <= 1'b0;
      rr_ptr_r  <= '0;
      job_id_r  <= '0;
      mul_mc_r  <= '0;
      mul_mp_r  <= '0;
      rsp_p_r   <= '0;
      rsp_id_r  <= '0;
      rsp_err_r <= 1'b0;
    end else begin
      done_q_r <= mul_done;
      if (xfer_s) begin
        mul_mc_r <= sel_mc_s;
        mul_mp_r <= sel_mp_s;
        job_id_r <= grant_id_s;
        rr_ptr_r <= rr_next_s;
      end
      if (done_rise_s) begin
        rsp_p_r   <= mul_p;
        rsp_id_r  <= job_id_r;
        rsp_err_r <= 1'b0;
      end else if (timeout_s) begin
        rsp_p_r   <= '0;
        rsp_id_r  <= job_id_r;
        rsp_err_r <= 1'b1;
      end
    end
  end

  assign cli.req_ready = grant_s;
  assign cli.rsp_valid = rsp_valid_r;
  assign cli.rsp_id    = rsp_id_r;
  assign cli.rsp_p     = rsp_p_r;
  assign cli.rsp_err   = rsp_err_r;
  assign busy          = busy_r;
  assign mul_start     = mul_start_r;
  assign mul_mc        = mul_mc_r;
  assign mul_mp        = mul_mp_r;

endmodule

// File: tb/tb_mul32_arb.sv
// tb_mul32_arb: directed bench for mul32_arb with a behavioural mul32 model
// and an expected-response queue.
module tb_mul32_arb;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int W       = 32;
  localparam int TIMEOUT = 20;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   p;
    logic           err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         busy;
  logic         mul_start;
  logic [W-1:0] mul_mc;
  logic [W-1:0] mul_mp;
  logic         mul_done;
  logic [W-1:0] mul_p;

  logic         man_mode;
  logic         man_done;
  logic [W-1:0] man_p;
  logic         model_done;
  logic [W-1:0] model_p;
  logic [3:0]   model_cnt;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  mul32_arb_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) cli ();

  mul32_arb #(.NREQ(NREQ), .IDW(IDW), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cli       (cli),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_mc    (mul_mc),
    .mul_mp    (mul_mp),
    .mul_done  (mul_done),
    .mul_p     (mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mul32 stand-in: done drops on start, rises 6 cycles later, stays high
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_done <= 1'b0;
      model_p    <= '0;
      model_cnt  <= 4'd0;
    end else if (mul_start) begin
      model_done <= 1'b0;
      model_cnt  <= 4'd5;
    end else if (model_cnt != 4'd0) begin
      model_cnt <= model_cnt - 4'd1;
      if (model_cnt == 4'd1) begin
        model_done <= 1'b1;
        model_p    <= mul_mc * mul_mp;
      end
    end
  end

  assign mul_done = man_mode ? man_done : model_done;
  assign mul_p    = man_mode ? man_p : model_p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] mc, input logic [W-1:0] mp);
    cli.req_mc[i*W +: W] = mc;
    cli.req_mp[i*W +: W] = mp;
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] p, input logic err);
    exp_t e;
    e.id  = IDW'(id);
    e.p   = p;
    e.err = err;
    sb_q.push_back(e);
  endtask

  // Wait for a grant, check it, and return at the negedge of the START cycle
  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp, input int budget);
    int n = 0;
    #1;
    while (cli.req_ready == '0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, cli.req_ready, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for a response, compare against the queue head, check it is one cycle
  task automatic wait_rsp(input string tag, input int budget);
    int   n = 0;
    exp_t e;
    while (!cli.rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " seen"}, cli.rsp_valid, 64'd1);
    if (cli.rsp_valid) begin
      chk({tag, " outstanding"}, sb_q.size(), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({tag, " id"}, cli.rsp_id, e.id);
        chk({tag, " p"}, cli.rsp_p, e.p);
        chk({tag, " err"}, cli.rsp_err, e.err);
      end
      @(negedge clk);
      chk({tag, " pulse"}, cli.rsp_valid, 64'd0);
      chk({tag, " idle"}, busy, 64'd0);
    end
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    man_mode      = 1'b0;
    man_done      = 1'b0;
    man_p         = '0;
    cli.req_valid = '0;
    cli.req_mc    = '0;
    cli.req_mp    = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("reset ready", cli.req_ready, 64'd0);
    chk("reset rsp_valid", cli.rsp_valid, 64'd0);
    chk("reset busy", busy, 64'd0);
    chk("reset start", mul_start, 64'd0);
    chk("reset mc", mul_mc, 64'd0);
    chk("reset rsp_p", cli.rsp_p, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // round-robin with all requesters valid: 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_req(i, W'((i + 1) * 3), 32'd7);
    cli.req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      push_exp(j % 4, W'(((j % 4) + 1) * 21), 1'b0);
      wait_grant($sformatf("rr grant %0d", j), NREQ'(1 << (j % 4)), 20);
      if (j == 4) cli.req_valid = '0;
      wait_rsp($sformatf("rr rsp %0d", j), 40);
    end

    // single request with latency checks
    set_req(0, 32'd1234, 32'd5678);
    cli.req_valid = 4'b0001;
    push_exp(0, 32'd7006652, 1'b0);
    wait_grant("single grant", 4'b0001, 10);
    cli.req_valid = '0;
    #1;
    chk("single start", mul_start, 64'd1);
    chk("single mc", mul_mc, 64'd1234);
    chk("single mp", mul_mp, 64'd5678);
    chk("single busy", busy, 64'd1);
    chk("single ready low", cli.req_ready, 64'd0);
    @(negedge clk);
    chk("single start once", mul_start, 64'd0);
    n = 0;
    while (!mul_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single no early rsp", cli.rsp_valid, 64'd0);
    @(negedge clk);
    wait_rsp("single rsp", 0);
    repeat (3) @(negedge clk);
    chk("rsp_p hold", cli.rsp_p, 64'd7006652);

    // serve 3 alone, then 1 and 3 valid: pointer wraps to 0 so 1 wins
    set_req(3, 32'd5, 32'd6);
    cli.req_valid = 4'b1000;
    push_exp(3, 32'd30, 1'b0);
    wait_grant("solo3 grant", 4'b1000, 10);
    cli.req_valid = '0;
    wait_rsp("solo3 rsp", 40);
    set_req(1, 32'd65535, 32'd65535);
    cli.req_valid = 4'b1010;
    push_exp(1, 32'd4294836225, 1'b0);
    wait_grant("wrap grant 1", 4'b0010, 10);
    wait_rsp("wrap rsp 1", 40);
    push_exp(3, 32'd30, 1'b0);
    wait_grant("wrap grant 3", 4'b1000, 10);
    cli.req_valid = '0;
    wait_rsp("wrap rsp 3", 40);

    // stale done held high across START: only a fresh rising edge completes
    man_mode = 1'b1;
    man_done = 1'b1;
    man_p    = 32'd99;
    set_req(2, 32'd9, 32'd11);
    cli.req_valid = 4'b0100;
    push_exp(2, 32'd99, 1'b0);
    wait_grant("stale grant", 4'b0100, 10);
    cli.req_valid = '0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (cli.rsp_valid) n++;
    end
    chk("stale no rsp", n, 64'd0);
    chk("stale busy", busy, 64'd1);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    wait_rsp("stale rsp", 5);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (cli.rsp_valid) n++;
    end
    chk("stale single rsp", n, 64'd0);
    man_done = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of BUSY aborts the job
    set_req(1, 32'd100, 32'd200);
    cli.req_valid = 4'b0010;
    wait_grant("abort grant", 4'b0010, 10);
    cli.req_valid = '0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst busy", busy, 64'd0);
    chk("arst start", mul_start, 64'd0);
    chk("arst mc", mul_mc, 64'd0);
    chk("arst mp", mul_mp, 64'd0);
    chk("arst rsp_p", cli.rsp_p, 64'd0);
    chk("arst rsp_id", cli.rsp_id, 64'd0);
    chk("arst rsp_err", cli.rsp_err, 64'd0);
    chk("arst rsp_valid", cli.rsp_valid, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    man_mode = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (cli.rsp_valid) n++;
    end
    chk("arst no rsp", n, 64'd0);
    set_req(2, 32'hFFFF_FFFF, 32'd2);
    cli.req_valid = 4'b0100;
    push_exp(2, 32'hFFFF_FFFE, 1'b0);
    wait_grant("post-reset grant", 4'b0100, 10);
    cli.req_valid = '0;
    wait_rsp("post-reset rsp", 40);

`ifdef MUL32_ARB_WDOG_EN
    // watchdog: done never rises, abort after TIMEOUT cycles in BUSY
    man_mode = 1'b1;
    man_done = 1'b0;
    man_p    = 32'd12345;
    set_req(1, 32'd7, 32'd8);
    cli.req_valid = 4'b0010;
    push_exp(1, 32'd0, 1'b1);
    wait_grant("wdog grant", 4'b0010, 10);
    cli.req_valid = '0;
    n = 0;
    while (!cli.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wdog latency", n, 64'(TIMEOUT + 1));
    wait_rsp("wdog rsp", 0);
    man_done = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (cli.rsp_valid) n++;
    end
    chk("wdog stray done", n, 64'd0);
    man_done = 1'b0;
    man_mode = 1'b0;
`endif

    chk("scoreboard drained", sb_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mul32_arb.md
Name: mul32_arb

Overview:
Controller and round-robin arbiter that shares one mul32 serial-parallel multiplier among NREQ requesters. It accepts one operand pair at a time over per-requester valid/ready, then registers the operands and pulses mul32's start. It waits for mul32's done and returns the product on a shared response bus tagged with the requester ID. It sits between client blocks and the single mul32 instance, driving that instance's start/mc/mp and observing its done/p.

Parameters:
NREQ, 4, number of requesters (2..2**IDW)
IDW, 2, width of the requester ID
W, 32, operand and product width (matches mul32)
TIMEOUT, 255, watchdog limit in cycles (used only with MUL32_ARB_WDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_mc  in  NREQ*W  packed multiplicands; requester i at [i*W +: W]
req_mp  in  NREQ*W  packed multipliers
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  IDW  requester owning rsp_p
rsp_p  out  W  product (held until next rsp_valid)
rsp_err  out  1  watchdog abort flag, valid with rsp_valid (tied 0 without feature)
busy  out  1  high in any state except IDLE
mul_start  out  1  start pulse to mul32
mul_mc  out  W  registered multiplicand to mul32
mul_mp  out  W  registered multiplier to mul32
mul_done  in  1  mul32 done (level; completion = rising edge)
mul_p  in  W  mul32 product

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, done_q=0. All outputs 0: req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, busy, mul_start, mul_mc, mul_mp. Reset mid-operation aborts the job; no response is issued.
- FSM states: IDLE, START, BUSY, RESP.
- IDLE: req_ready is combinational. One-hot for the first i with req_valid[i], searching from rr_ptr upward with wrap at NREQ-1 -> 0. All zero if no valid.
- On a transfer edge: latch req_mc[i] -> mul_mc, req_mp[i] -> mul_mp, and i -> job_id. Set rr_ptr = (i+1) mod NREQ. Go to START.
- START: mul_start=1 for exactly one cycle; then BUSY. Operands are stable for one full cycle before start and held unchanged until RESP.
- BUSY: done_q registers mul_done every cycle. Completion = mul_done & ~done_q. A done level left high from the prior job is ignored. On completion: rsp_p <= mul_p, rsp_id <= job_id, rsp_err <= 0; go to RESP.
- RESP: rsp_valid=1 for one cycle; return to IDLE. req_ready is 0 in START, BUSY and RESP.
- Latency: transfer edge T -> mul_start high in cycle T+1 -> rsp_valid high the cycle after the done rising edge is sampled.
- Requesters must hold req_mc/req_mp stable while req_valid is high. No response backpressure.
- Fairness: a continuously requesting client is granted at most once per NREQ grants when all requesters are active.
- req_valid for indices >= NREQ does not exist. A requester dropping valid before grant is legal; it is simply not selected.
- rsp_p keeps its last value between responses.

Optional Feature:
MUL32_ARB_WDOG_EN
- Defined: an 8-bit-or-wider cycle counter clears on START and increments in BUSY. If it reaches TIMEOUT before completion: rsp_p <= 0, rsp_err <= 1, rsp_id <= job_id, go to RESP. A later stray done edge is ignored unless in BUSY.
- Undefined: no counter; BUSY waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset: rst asserted mid-BUSY (async, between clock edges) -> all outputs 0 immediately; no rsp_valid after release. A new request from requester 2 then completes normally.
- Single request: req_valid[0]=1, mc=1234, mp=5678 with a mul32 model -> req_ready[0] pulses 1 cycle, mul_start 1 cycle later, then rsp_valid with rsp_id=0, rsp_p=7006652.
- Round-robin: all 4 requesters valid continuously with operands (i+1)*3 x 7 -> grant order 0,1,2,3,0 and products 21,42,63,84.
- Wrap / pointer: after serving requester 3, only requesters 1 and 3 valid -> requester 1 granted first. Operands 65535 x 65535 -> rsp_p=4294836225.
- Stale done: hold mul_done high through the next START -> no completion until done falls then rises; exactly one rsp_valid per job.
- Watchdog (MUL32_ARB_WDOG_EN, TIMEOUT=20): mul_done never rises -> rsp_valid 20 cycles after entering BUSY with rsp_err=1, rsp_p=0, busy=0 afterwards.
